// File: rtl/ann_pkg.sv
// Shared constants and types for the layer-0 neuron array: Q8.8 format,
// neuron fan-in, accumulator width and the MAC sequencer state encoding.
package ann_pkg;

  localparam int N_IN      = 28;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FINAL = 2'd3
  } state_t;

endpackage

// File: rtl/q_round_sat.sv
// Combinational requantiser: rounds a wide fixed-point accumulator half-up,
// drops FRAC_BITS fractional bits and saturates to a DATA_W signed word.
// Shared with the later layers, hence fully parameterised.
module q_round_sat
  import ann_pkg::*;
#(
  parameter int ACC_W     = ann_pkg::ACC_W,
  parameter int DATA_W    = ann_pkg::DATA_W,
  parameter int FRAC_BITS = ann_pkg::FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [DATA_W-1:0] q_out
);

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (DATA_W - 1));

  function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] v);
    return (v + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

  // Round, shift and clamp in one combinational path
  always_comb begin
    q_out = saturate(round_half_up(acc_in));
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron multiply-accumulate sequencer. Walks the weight BRAM and the
// activation buffer in lockstep, accumulates N_IN signed Q8.8 products, adds
// the bias and emits one rounded, saturated Q8.8 result per START.
// Optional build macro NEURON_RELU_EN clamps negative results to zero.
module neuron_mac_unit
  import ann_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  input  logic [DATA_W-1:0] W_DO,
  output logic [ADDR_W-1:0] X_ADDR,
  input  logic [DATA_W-1:0] X_DO,
  output logic              BUSY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA
);

  // Address whose presentation hands over from FETCH to DRAIN
  localparam logic [ADDR_W-1:0] LAST_FETCH_ADDR = ADDR_W'(N_IN - 2);

  state_t                   state;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_en;
  logic                     busy;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0]  acc;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    biased_sum;
  logic signed [DATA_W-1:0]   sat_res;
  logic signed [DATA_W-1:0]   final_res;

  // Full-precision product and bias alignment into the accumulator format
  always_comb begin
    prod       = $signed(W_DO) * $signed(X_DO);
    prod_ext   = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    biased_sum = acc + {{(ACC_W - DATA_W - FRAC_BITS){bias_q[DATA_W-1]}}, bias_q, {FRAC_BITS{1'b0}}};
  end

  q_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc_in (biased_sum),
    .q_out  (sat_res)
  );

`ifdef NEURON_RELU_EN
  assign final_res = sat_res[DATA_W-1] ? '0 : sat_res;
`else
  assign final_res = sat_res;
`endif

  // Sequencer: address generation, accumulation and result registration.
  // The registered enable doubles as the data-valid flag: when it is high the
  // BRAM data now on W_DO/X_DO belongs to the previously presented address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      w_addr    <= '0;
      w_en      <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      bias_q    <= '0;
      acc       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            acc    <= '0;
            bias_q <= $signed(BIAS);
            w_en   <= 1'b1;
            w_addr <= '0;
            busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (w_en) acc <= acc + prod_ext;
          w_addr <= w_addr + 1'b1;
          if (w_addr == LAST_FETCH_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          if (w_en) acc <= acc + prod_ext;
          w_en   <= 1'b0;
          w_addr <= '0;
          state  <= FINAL;
        end
        FINAL: begin
          out_data  <= final_res;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign W_ADDR    = w_addr;
  assign X_ADDR    = w_addr;
  assign W_EN      = w_en;
  assign BUSY      = busy;
  assign OUT_VALID = out_valid;
  assign OUT_DATA  = out_data;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Scoreboard bench for neuron_mac_unit: stimulus pushes expected results and
// due cycles, an independent monitor pops them on every OUT_VALID.
module tb_neuron_mac_unit;
  import ann_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              START = 1'b0;
  logic [DATA_W-1:0] BIAS = '0;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic [DATA_W-1:0] W_DO = '0;
  logic [ADDR_W-1:0] X_ADDR;
  logic [DATA_W-1:0] X_DO = '0;
  logic              BUSY;
  logic              OUT_VALID;
  logic [DATA_W-1:0] OUT_DATA;

  neuron_mac_unit dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .BIAS      (BIAS),
    .W_ADDR    (W_ADDR),
    .W_EN      (W_EN),
    .W_DO      (W_DO),
    .X_ADDR    (X_ADDR),
    .X_DO      (X_DO),
    .BUSY      (BUSY),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA)
  );

  always #5 CLK = ~CLK;

  // Weight BRAM and activation buffer: read data registered on falling edge
  logic [DATA_W-1:0] wmem [0:31];
  logic [DATA_W-1:0] xmem [0:31];
  always @(negedge CLK) begin
    if (W_EN) begin
      W_DO <= wmem[W_ADDR];
      X_DO <= xmem[X_ADDR];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every OUT_VALID must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", {16'd0, OUT_DATA}, {16'd0, mon_e.data});
        check("out_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic fill(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] x);
    for (int i = 0; i < 32; i++) begin
      wmem[i] = w;
      xmem[i] = x;
    end
  endtask

  // Pulse START for one edge; optionally register the expected outcome
  task automatic pulse_start(input logic [DATA_W-1:0] b, input bit push, input logic [DATA_W-1:0] res);
    exp_t e;
    START = 1'b1;
    BIAS  = b;
    if (push) begin
      e.data = res;
      e.due  = cyc + 1 + N_IN + 1;
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic run(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] x,
                     input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] res);
    fill(w, x);
    pulse_start(b, 1'b1, res);
    wait_idle();
  endtask

  initial begin
    int en_cnt;
    int n;
    fill('0, '0);

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_w_en", {31'd0, W_EN}, 32'd0);
    check("rst_w_addr", {27'd0, W_ADDR}, 32'd0);
    check("rst_x_addr", {27'd0, X_ADDR}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_out_data", {16'd0, OUT_DATA}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // 1.0 * 1.0 over all inputs, with address/enable sequence checks
    fill(16'h0100, 16'h0100);
    pulse_start(16'h0000, 1'b1, 16'h1C00);
    check("busy_after_start", {31'd0, BUSY}, 32'd1);
    en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (W_EN) begin
        check("w_addr_seq", {27'd0, W_ADDR}, en_cnt);
        check("x_addr_eq", {27'd0, X_ADDR}, {27'd0, W_ADDR});
        en_cnt++;
      end
      @(posedge CLK); #1;
    end
    check("w_en_cycles", en_cnt, N_IN);
    wait_idle();

    // Sign, saturation, bias and rounding vectors
`ifdef NEURON_RELU_EN
    run(16'hFF00, 16'h0100, 16'h0000, 16'h0000);
    run(16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
`else
    run(16'hFF00, 16'h0100, 16'h0000, 16'hE400);
    run(16'h8000, 16'h7FFF, 16'h0000, 16'h8000);
`endif
    run(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run(16'h0000, 16'h0100, 16'h0280, 16'h0280);
    fill('0, '0);
    wmem[0] = 16'h0080;
    xmem[0] = 16'h0001;
    pulse_start(16'h0000, 1'b1, 16'h0001);
    wait_idle();

    // START while busy is ignored, START on the OUT_VALID cycle is accepted
    fill(16'h0100, 16'h0100);
    pulse_start(16'h0000, 1'b1, 16'h1C00);
    repeat (3) @(posedge CLK); #1;
    pulse_start(16'h7FFF, 1'b0, 16'h0000);
    n = 0;
    while (!OUT_VALID && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    check("first_out_valid_seen", {31'd0, OUT_VALID}, 32'd1);
    pulse_start(16'h0100, 1'b1, 16'h1D00);
    check("busy_after_b2b_start", {31'd0, BUSY}, 32'd1);
    wait_idle();

    // Reset in mid-computation discards the work and emits nothing
    pulse_start(16'h0000, 1'b0, 16'h0000);
    repeat (9) @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    check("midrst_w_en", {31'd0, W_EN}, 32'd0);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    check("midrst_w_addr", {27'd0, W_ADDR}, 32'd0);
    repeat (2) @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (40) @(posedge CLK); #1;
    check("midrst_idle", {31'd0, BUSY}, 32'd0);
    run(16'h0100, 16'h0100, 16'h0000, 16'h1C00);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule
